// File: rtl/alu_seq_ext.sv
// rtl/alu_seq_ext.sv - multi-cycle extended ALU with iterative restoring divider
//
// Purpose: single-cycle AND/OR/XOR/ADD/SUB/SLT/SLTU and WIDTH+1 cycle
// unsigned DIV/MOD behind a Start/Busy/Done handshake. Result and flags are
// registered and hold between operations.
// Optional feature macro: ALU_SIGNED_DIV_EN (DIV/MOD with i_bnegate=1 become
// signed two's complement; quotient truncates toward zero, remainder takes
// the sign of the dividend).
//
// Ports:
//   i_clock       rising-edge clock
//   i_reset       asynchronous active-high reset
//   i_start       op request, sampled only while o_busy=0
//   i_a, i_b      operand A / dividend, operand B / divisor (WIDTH)
//   i_bnegate     invert B with carry-in 1 (SUB); signed select for DIV/MOD
//   i_aluctrl     op select (3 bits)
//   o_busy        multi-cycle op in progress
//   o_done        one-cycle pulse, result valid
//   o_rez         registered result (WIDTH)
//   o_zero        o_rez == 0
//   o_overflow    signed overflow
//   o_carryout    adder carry out
//   o_divbyzero   DIV/MOD with B == 0
module alu_seq_ext #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bnegate,
  input  logic [2:0]       i_aluctrl,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_rez,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_carryout,
  output logic             o_divbyzero
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_t;

  state_t           r_state, w_next;
  logic             r_busy, r_done, r_zero, r_ovf, r_cout, r_dbz, r_mod;
  logic [WIDTH-1:0] r_rez, r_rem, r_quo, r_dvs;
  logic [CNT_W-1:0] r_cnt;

  logic             w_is_div, w_b_nz;
  logic [WIDTH-1:0] w_bop, w_res, w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf, w_cout, w_dbz;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff, w_rem_nxt;
  logic [WIDTH-1:0] w_q, w_r, w_fin_res;
  logic             w_fin_ovf;

  assign w_is_div = (i_aluctrl[2:1] == 2'b11);
  assign w_b_nz   = (i_b != '0);

  // Adder shared by ADD/SUB: B is inverted and carry-in set for SUB.
  assign w_bop = i_bnegate ? ~i_b : i_b;
  assign w_sum = {1'b0, i_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, i_bnegate};

  always_comb begin
    w_res  = '0;
    w_ovf  = 1'b0;
    w_cout = 1'b0;
    w_dbz  = 1'b0;
    case (i_aluctrl)
      3'b000: w_res = i_a & i_b;
      3'b001: w_res = i_a | i_b;
      3'b011: w_res = i_a ^ i_b;
      3'b010: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = (i_a[MSB] == w_bop[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      3'b100: w_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      3'b101: w_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      // DIV/MOD only reach here when B == 0; nonzero divisors go to S_DIV.
      3'b110: begin w_res = i_a; w_dbz = 1'b1; end
      default: begin w_res = '1; w_dbz = 1'b1; end
    endcase
  end

`ifdef ALU_SIGNED_DIV_EN
  logic r_neg_q, r_neg_r, r_sovf;
  assign w_a_mag = (i_bnegate && i_a[MSB]) ? (~i_a + WIDTH'(1)) : i_a;
  assign w_b_mag = (i_bnegate && i_b[MSB]) ? (~i_b + WIDTH'(1)) : i_b;
  // Most-negative / -1 yields magnitude quotient = most-negative, which
  // already reads back correctly unnegated; only the flag needs raising.
  assign w_q       = r_neg_q ? (~r_quo + WIDTH'(1)) : r_quo;
  assign w_r       = r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;
  assign w_fin_ovf = r_sovf && !r_mod;
`else
  assign w_a_mag   = i_a;
  assign w_b_mag   = i_b;
  assign w_q       = r_quo;
  assign w_r       = r_rem;
  assign w_fin_ovf = 1'b0;
`endif

  assign w_fin_res = r_mod ? w_r : w_q;

  // One restoring step: r_quo shifts the dividend out at the top while
  // quotient bits enter at the bottom.
  assign w_shift   = {r_rem, r_quo[MSB]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_diff    = w_shift[WIDTH-1:0] - r_dvs;
  assign w_rem_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start && w_is_div && w_b_nz) w_next = S_DIV;
      // The step taken with r_cnt==1 is the last; count reaches 0 as we leave.
      S_DIV:  if (r_cnt == CNT_W'(1)) w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_busy <= 1'b0; r_done <= 1'b0; r_rez  <= '0;   r_zero <= 1'b0;
      r_ovf  <= 1'b0; r_cout <= 1'b0; r_dbz  <= 1'b0; r_mod  <= 1'b0;
      r_rem  <= '0;   r_quo  <= '0;   r_dvs  <= '0;   r_cnt  <= '0;
`ifdef ALU_SIGNED_DIV_EN
      r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_sovf <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_is_div && w_b_nz) begin
              r_rem  <= '0;
              r_quo  <= w_a_mag;
              r_dvs  <= w_b_mag;
              r_cnt  <= CNT_W'(WIDTH);
              r_mod  <= ~i_aluctrl[0];
              r_busy <= 1'b1;
`ifdef ALU_SIGNED_DIV_EN
              r_neg_q <= i_bnegate && (i_a[MSB] ^ i_b[MSB]);
              r_neg_r <= i_bnegate && i_a[MSB];
              r_sovf  <= i_bnegate && (i_a == {1'b1, {(WIDTH-1){1'b0}}})
                         && (i_b == '1);
`endif
            end else begin
              r_rez  <= w_res;
              r_zero <= (w_res == '0);
              r_ovf  <= w_ovf;
              r_cout <= w_cout;
              r_dbz  <= w_dbz;
              r_done <= 1'b1;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIN: begin
          r_rez  <= w_fin_res;
          r_zero <= (w_fin_res == '0);
          r_ovf  <= w_fin_ovf;
          r_cout <= 1'b0;
          r_dbz  <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rez       = r_rez;
  assign o_zero      = r_zero;
  assign o_overflow  = r_ovf;
  assign o_carryout  = r_cout;
  assign o_divbyzero = r_dbz;

endmodule

// File: tb/tb_alu_seq_ext.sv
// tb/tb_alu_seq_ext.sv - directed self-checking bench for alu_seq_ext
module tb_alu_seq_ext;

  localparam int W = 16;

  logic         clk, rst, start, bneg;
  logic [W-1:0] a, b;
  logic [2:0]   ctrl;
  logic         busy, done, zero, ovf, cout, dbz;
  logic [W-1:0] rez;

  int n_checks = 0;
  int n_errors = 0;
  int lat, bcnt, dcnt;

  alu_seq_ext #(.WIDTH(W)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_a(a), .i_b(b),
    .i_bnegate(bneg), .i_aluctrl(ctrl), .o_busy(busy), .o_done(done),
    .o_rez(rez), .o_zero(zero), .o_overflow(ovf), .o_carryout(cout),
    .o_divbyzero(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present the op, let one posedge sample it, drop Start.
  task automatic issue(input logic [2:0] c, input logic bn, input logic [W-1:0] va, input logic [W-1:0] vb);
    ctrl = c; bneg = bn; a = va; b = vb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts posedges after the Start edge until Done; optional ignored Start
  // with different operands injected mid-operation.
  task automatic wait_done(input logic poke, output int l, output int bc);
    l = 0; bc = 0;
    while (!done && l < 200) begin
      if (busy) bc++;
      if (poke && l == 5) begin
        ctrl = 3'b111; a = 16'h0FFF; b = 16'h0001; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      l++;
    end
    if (l >= 200) check("done_timeout", 32'(l), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bneg = 1'b0; a = '0; b = '0; ctrl = '0;
    @(negedge clk); @(negedge clk);
    check("rst_rez", 32'(rez), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_flags", {28'h0, zero, ovf, cout, dbz}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // ADD signed overflow
    issue(3'b010, 1'b0, 16'h7FFF, 16'h0001);
    wait_done(1'b0, lat, bcnt);
    check("add_lat", 32'(lat), 32'd0);
    check("add_rez", 32'(rez), 32'h8000);
    check("add_flags", {29'h0, zero, ovf, cout}, 32'b010);
    @(negedge clk);
    check("add_done_pulse", 32'(done), 32'h0);
    check("add_hold", 32'(rez), 32'h8000);

    // ADD carry out to zero
    issue(3'b010, 1'b0, 16'hFFFF, 16'h0001);
    wait_done(1'b0, lat, bcnt);
    check("addc_rez", 32'(rez), 32'h0);
    check("addc_flags", {29'h0, zero, ovf, cout}, 32'b101);

    // SUB equal -> zero
    issue(3'b010, 1'b1, 16'h0005, 16'h0005);
    wait_done(1'b0, lat, bcnt);
    check("sub_rez", 32'(rez), 32'h0);
    check("sub_flags", {29'h0, zero, ovf, cout}, 32'b101);

    issue(3'b100, 1'b0, 16'hFFFE, 16'h0001);
    wait_done(1'b0, lat, bcnt);
    check("slt_rez", 32'(rez), 32'h1);
    check("slt_flags", {29'h0, zero, ovf, cout}, 32'b000);

    issue(3'b101, 1'b0, 16'hFFFE, 16'h0001);
    wait_done(1'b0, lat, bcnt);
    check("sltu_rez", 32'(rez), 32'h0);

    issue(3'b000, 1'b0, 16'hF0F0, 16'hFF00);
    wait_done(1'b0, lat, bcnt);
    check("and_rez", 32'(rez), 32'hF000);
    issue(3'b001, 1'b1, 16'hF0F0, 16'h0F0F);
    wait_done(1'b0, lat, bcnt);
    check("or_rez", 32'(rez), 32'hFFFF);
    issue(3'b011, 1'b1, 16'hAAAA, 16'hAAAA);
    wait_done(1'b0, lat, bcnt);
    check("xor_rez", 32'(rez), 32'h0);
    check("xor_zero", 32'(zero), 32'h1);

    // Back-to-back remainder and quotient on the Done cycle, with an ignored Start
    issue(3'b110, 1'b0, 16'd100, 16'd7);
    wait_done(1'b1, lat, bcnt);
    check("mod_lat", 32'(lat), 32'(W + 1));
    check("mod_busy_cycles", 32'(bcnt), 32'(W + 1));
    check("mod_rez", 32'(rez), 32'h2);
    check("mod_done_busy", 32'(busy), 32'h0);
    issue(3'b111, 1'b0, 16'd100, 16'd7);
    wait_done(1'b1, lat, bcnt);
    check("div_lat", 32'(lat), 32'(W + 1));
    check("div_busy_cycles", 32'(bcnt), 32'(W + 1));
    check("div_rez", 32'(rez), 32'hE);
    check("div_flags", {28'h0, zero, ovf, cout, dbz}, 32'h0);
    @(negedge clk);
    check("div_done_pulse", 32'(done), 32'h0);

    // Divide by zero
    issue(3'b111, 1'b0, 16'h1234, 16'h0000);
    wait_done(1'b0, lat, bcnt);
    check("dbz_div_lat", 32'(lat), 32'd0);
    check("dbz_div_rez", 32'(rez), 32'hFFFF);
    check("dbz_div_flag", 32'(dbz), 32'h1);
    issue(3'b110, 1'b0, 16'h1234, 16'h0000);
    wait_done(1'b0, lat, bcnt);
    check("dbz_mod_rez", 32'(rez), 32'h1234);
    check("dbz_mod_flag", 32'(dbz), 32'h1);

    // Reset mid-divide
    issue(3'b111, 1'b0, 16'hFFFF, 16'h0003);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_rez", 32'(rez), 32'h0);
    check("arst_flags", {27'h0, done, zero, ovf, cout, dbz}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("arst_no_done", 32'(dcnt), 32'h0);
    issue(3'b111, 1'b0, 16'd9, 16'd3);
    wait_done(1'b0, lat, bcnt);
    check("post_rst_div_lat", 32'(lat), 32'(W + 1));
    check("post_rst_div_rez", 32'(rez), 32'h3);

    // BNegate on DIV/MOD
    issue(3'b111, 1'b1, 16'hFFF9, 16'h0002);
    wait_done(1'b0, lat, bcnt);
    check("sdiv_lat", 32'(lat), 32'(W + 1));
`ifdef ALU_SIGNED_DIV_EN
    check("sdiv_rez", 32'(rez), 32'hFFFD);
    issue(3'b110, 1'b1, 16'hFFF9, 16'h0002);
    wait_done(1'b0, lat, bcnt);
    check("smod_rez", 32'(rez), 32'hFFFF);
    issue(3'b111, 1'b1, 16'h8000, 16'hFFFF);
    wait_done(1'b0, lat, bcnt);
    check("sdiv_ovf_rez", 32'(rez), 32'h8000);
    check("sdiv_ovf_flag", 32'(ovf), 32'h1);
    issue(3'b110, 1'b1, 16'h8000, 16'hFFFF);
    wait_done(1'b0, lat, bcnt);
    check("smod_ovf_rez", 32'(rez), 32'h0);
`else
    check("udiv_bneg_rez", 32'(rez), 32'h7FFC);
    issue(3'b110, 1'b1, 16'hFFF9, 16'h0002);
    wait_done(1'b0, lat, bcnt);
    check("umod_bneg_rez", 32'(rez), 32'h1);
    issue(3'b111, 1'b1, 16'h8000, 16'hFFFF);
    wait_done(1'b0, lat, bcnt);
    check("udiv_min_rez", 32'(rez), 32'h0);
    check("udiv_min_ovf", 32'(ovf), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ext.md
Name: alu_seq_ext

Overview:
- Parametrised, multi-cycle successor to the 16-bit extended ALU. Width is set by a parameter.
- Single-cycle logic, arithmetic and compare ops complete in 1 cycle. Iterative restoring DIV/MOD ops complete in WIDTH+1 cycles.
- Start/Busy/Done handshake. Operands, result and flags are registered.
- Sits in the CPU execute stage; the control unit stalls on Busy.

Parameters:
- WIDTH, 16, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  op request; sampled only when Busy=0.
- A  input  WIDTH  operand A / dividend.
- B  input  WIDTH  operand B / divisor.
- BNegate  input  1  invert B and add carry-in 1 (SUB).
- ALUCtrl  input  3  op select.
- Busy  output  1  multi-cycle op in progress.
- Done  output  1  one-cycle pulse, result valid.
- REZ  output  WIDTH  registered result.
- Zero  output  1  REZ==0, registered with REZ.
- Overflow  output  1  signed overflow.
- CarryOut  output  1  adder carry out.
- DivByZero  output  1  DIV/MOD with B==0.

Behaviour:
- Reset (async, active-high): state IDLE; Busy, Done, REZ, Zero, Overflow, CarryOut, DivByZero = 0; shift/quotient/count registers = 0. Reset mid-divide discards the partial result; no Done.
- ALUCtrl ops:
  - 000 AND; 001 OR; 011 XOR (BNegate ignored for logic ops).
  - 010 ADD; SUB when BNegate=1 (A + ~B + 1).
  - 100 SLT signed (REZ = {0…,1} when A<B signed); 101 SLTU.
  - 110 MOD unsigned; 111 DIV unsigned.
- FSM states:
  - IDLE: Start=1 with a single-cycle op → at that edge, write REZ and flags and set Done=1 next cycle; stay IDLE. Start=1 with DIV/MOD and B≠0 → latch A, B, op; clear remainder; count=WIDTH; Busy=1; go to DIV. Start=1 with DIV/MOD and B==0 → single-cycle: DIV REZ = all ones, MOD REZ = A, DivByZero=1, Done pulse.
  - DIV: one restoring step per edge (shift remainder left by 1 with the next dividend bit, trial-subtract, set quotient bit); count decrements; at count==0 go to FIN.
  - FIN: write REZ (quotient or remainder) and flags; Busy=0; Done=1 for one cycle; go to IDLE.
- Latency:
  - Single-cycle ops: Done high in the cycle after the Start edge.
  - DIV/MOD: Start sampled at edge t → Done high after edge t+WIDTH+1. Busy is high for exactly WIDTH+1 cycles.
- Operands are latched at Start; A/B/ALUCtrl changes while Busy=1 have no effect.
- Start while Busy=1 is ignored (no queueing).
- Back-to-back: Start may be asserted in the cycle Done is high; it is accepted because Busy=0.
- Flags:
  - Overflow/CarryOut are meaningful for ADD/SUB only. Overflow = (A[msb]==B'[msb]) && (sum[msb]≠A[msb]), where B' is the inverted B when BNegate=1.
  - CarryOut and Overflow are 0 for all other ops, except the signed-DIV case under the optional feature.
  - DivByZero is 0 except on a div-by-zero result.
  - Zero is computed from the new REZ.
- REZ and flags hold between ops; Done is never high for more than one consecutive cycle per op.

Optional Feature:
- Macro: ALU_SIGNED_DIV_EN.
- Defined: DIV/MOD with BNegate=1 are signed two's complement.
  - Operands are converted to magnitudes at Start; sign fix-up is applied in FIN; latency is unchanged.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative ÷ −1: DIV REZ = most-negative with Overflow=1; MOD REZ = 0.
  - Divide-by-zero: as unsigned (DIV all ones, MOD = A, DivByZero=1).
- Undefined: BNegate is ignored for DIV/MOD (always unsigned); no sign logic is synthesised.

Test Plan:
- ADD 0x7FFF+0x0001 (ALUCtrl=010, BNegate=0) → REZ=0x8000, Overflow=1, CarryOut=0, Zero=0, Done one cycle after Start.
- SUB 0x0005−0x0005 (BNegate=1) → REZ=0x0000, Zero=1, CarryOut=1, Overflow=0; then SLT 0xFFFE vs 0x0001 → REZ=0x0001.
- MOD 100%7 then DIV 100/7 issued back-to-back on the Done cycle → REZ=0x0002 then 0x000E; each Done exactly 17 cycles after its Start; Busy high for 17 cycles; a Start mid-op with other operands is ignored.
- DIV 0x1234/0 → REZ=0xFFFF, DivByZero=1, Done after 1 cycle; MOD 0x1234%0 → REZ=0x1234.
- Reset asserted at cycle 8 of DIV 0xFFFF/3 → outputs 0 immediately (asynchronously), no Done; a new DIV 9/3 after release → REZ=0x0003.
- With ALU_SIGNED_DIV_EN defined, BNegate=1:
  - 0xFFF9 DIV 2 → 0xFFFD.
  - 0xFFF9 MOD 2 → 0xFFFF.
  - 0x8000 DIV 0xFFFF → 0x8000, Overflow=1.
  - Without the macro, 0xFFF9 DIV 2 → 0x7FFC.
